// File: rtl/rv_decode_pkg.sv
// Shared encodings and the decoded-instruction bundle for the RV32I decode stage.
package rv_decode_pkg;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpReg     = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  // ResMdCsr is shared; md_op[3] tells the mul/div unit apart from the CSR file.
  localparam logic [1:0] ResAlu = 2'b00, ResMem = 2'b01, ResPcP4 = 2'b10, ResMdCsr = 2'b11;

  localparam logic [2:0] AluAdd = 3'd0, AluSub = 3'd1, AluSll = 3'd2, AluSrl = 3'd3,
                         AluSra = 3'd4, AluXor = 3'd5, AluOr  = 3'd6, AluAnd = 3'd7;
  localparam logic [2:0] CmpNone = 3'd0, CmpEq = 3'd1, CmpNe  = 3'd2, CmpLt = 3'd3,
                         CmpGe   = 3'd4, CmpLtu = 3'd5, CmpGeu = 3'd6;

  localparam logic [1:0] Op1Rs1 = 2'd0, Op1Pc = 2'd1, Op1Zero = 2'd2;
  localparam logic       Op2Rs2 = 1'b0, Op2Imm = 1'b1;

  typedef enum logic [1:0] {
    ExcNone    = 2'b00,
    ExcEcall   = 2'b01,
    ExcEbreak  = 2'b10,
    ExcIllegal = 2'b11
  } exc_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [29:0] pc;
    logic [29:0] pc_p4;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        pc_sel;
    logic [1:0]  res_src;
    logic [1:0]  alu_op1_sel;
    logic        alu_op2_sel;
    logic [2:0]  funct3;
    logic [5:0]  alu_ctrl;
    logic [3:0]  md_op;
    logic [2:0]  csr_op;
    exc_e        exc;
  } dec_bundle_t;

  // alt selects SUB/SRA; set-less-than runs as a subtract with a compare.
  function automatic logic [5:0] alu_ctrl_of(input logic [2:0] funct3, input logic alt);
    logic [5:0] ctrl;
    case (funct3)
      3'b000:  ctrl = {CmpNone, alt ? AluSub : AluAdd};
      3'b001:  ctrl = {CmpNone, AluSll};
      3'b010:  ctrl = {CmpLt, AluSub};
      3'b011:  ctrl = {CmpLtu, AluSub};
      3'b100:  ctrl = {CmpNone, AluXor};
      3'b101:  ctrl = {CmpNone, alt ? AluSra : AluSrl};
      3'b110:  ctrl = {CmpNone, AluOr};
      default: ctrl = {CmpNone, AluAnd};
    endcase
    return ctrl;
  endfunction

  function automatic logic [2:0] branch_cmp(input logic [2:0] funct3);
    logic [2:0] cmp;
    case (funct3)
      3'b000:  cmp = CmpEq;
      3'b001:  cmp = CmpNe;
      3'b100:  cmp = CmpLt;
      3'b101:  cmp = CmpGe;
      3'b110:  cmp = CmpLtu;
      default: cmp = CmpGeu;
    endcase
    return cmp;
  endfunction

endpackage

// File: rtl/rv_decode_pipe_if.sv
// Fetch-side and execute-side handshakes of the decode stage in one bundle.
interface rv_decode_pipe_if;
  import rv_decode_pkg::*;

  logic        valid;
  logic        ready;
  logic        flush;
  logic [31:0] data;
  logic [29:0] pc;
  logic [29:0] pc_p4;
  logic        dec_valid;
  logic        dec_ready;
  dec_bundle_t dec;
  logic        inv_instr;

  modport master (
    output valid, flush, data, pc, pc_p4, dec_ready,
    input  ready, dec_valid, dec, inv_instr
  );

  modport slave (
    input  valid, flush, data, pc, pc_p4, dec_ready,
    output ready, dec_valid, dec, inv_instr
  );
endinterface

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I decoder with optional M, Zicsr/SYSTEM and FENCE support.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter bit EN_M     = 1'b0,
  parameter bit EN_ZICSR = 1'b0,
  parameter bit EN_FENCE = 1'b1
) (
  input  logic [31:0] data,
  input  logic [29:0] pc,
  input  logic [29:0] pc_p4,
  output dec_bundle_t dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;

  assign opcode = data[6:0];
  assign f3     = data[14:12];
  assign f7     = data[31:25];
  assign imm_i  = {{20{data[31]}}, data[31:20]};
  assign imm_s  = {{20{data[31]}}, data[31:25], data[11:7]};
  assign imm_b  = {{19{data[31]}}, data[31], data[7], data[30:25], data[11:8], 1'b0};
  assign imm_u  = {data[31:12], 12'b0};
  assign imm_j  = {{11{data[31]}}, data[31], data[19:12], data[20], data[30:21], 1'b0};

  always_comb begin
    illegal         = 1'b0;
    dec             = '0;
    dec.rs1         = data[19:15];
    dec.rs2         = data[24:20];
    dec.rd          = data[11:7];
    dec.pc          = pc;
    dec.pc_p4       = pc_p4;
    dec.funct3      = f3;
    dec.res_src     = ResAlu;
    dec.alu_op1_sel = Op1Rs1;
    dec.alu_op2_sel = Op2Rs2;
    dec.alu_ctrl    = {CmpNone, AluAdd};
    dec.exc         = ExcNone;

    case (opcode)
      OpLui: begin
        dec.reg_write   = 1'b1;
        dec.alu_op1_sel = Op1Zero;
        dec.alu_op2_sel = Op2Imm;
        dec.imm         = imm_u;
      end
      OpAuipc: begin
        dec.reg_write   = 1'b1;
        dec.alu_op1_sel = Op1Pc;
        dec.alu_op2_sel = Op2Imm;
        dec.imm         = imm_u;
      end
      OpJal: begin
        dec.jump        = 1'b1;
        dec.reg_write   = 1'b1;
        dec.res_src     = ResPcP4;
        dec.alu_op1_sel = Op1Pc;
        dec.alu_op2_sel = Op2Imm;
        dec.imm         = imm_j;
      end
      OpJalr: begin
        illegal         = f3 != 3'b000;
        dec.jump        = 1'b1;
        dec.pc_sel      = 1'b1;
        dec.reg_write   = 1'b1;
        dec.res_src     = ResPcP4;
        dec.alu_op2_sel = Op2Imm;
        dec.imm         = imm_i;
      end
      OpBranch: begin
        illegal      = f3[2:1] == 2'b01;
        dec.branch   = 1'b1;
        dec.imm      = imm_b;
        dec.alu_ctrl = {branch_cmp(f3), AluSub};
      end
      OpLoad: begin
        illegal         = f3 == 3'b011 || f3[2:1] == 2'b11;
        dec.mem_read    = 1'b1;
        dec.reg_write   = 1'b1;
        dec.res_src     = ResMem;
        dec.alu_op2_sel = Op2Imm;
        dec.imm         = imm_i;
      end
      OpStore: begin
        illegal         = f3[2] || f3 == 3'b011;
        dec.mem_write   = 1'b1;
        dec.alu_op2_sel = Op2Imm;
        dec.imm         = imm_s;
      end
      OpImm: begin
        dec.reg_write   = 1'b1;
        dec.alu_op2_sel = Op2Imm;
        dec.imm         = imm_i;
        dec.alu_ctrl    = alu_ctrl_of(f3, f3 == 3'b101 && f7[5]);
        if (f3 == 3'b001) illegal = f7 != 7'b0000000;
        else if (f3 == 3'b101) illegal = f7 != 7'b0000000 && f7 != 7'b0100000;
      end
      OpReg: begin
        dec.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_ctrl = alu_ctrl_of(f3, 1'b0);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec.alu_ctrl = alu_ctrl_of(f3, 1'b1);
        end else if (f7 == 7'b0000001 && EN_M) begin
          dec.md_op   = {1'b1, f3};
          dec.res_src = ResMdCsr;
        end else begin
          illegal = 1'b1;
        end
      end
      OpMiscMem: begin
        // FENCE/FENCE.I retire as NOPs on this in-order core.
        illegal = !EN_FENCE || f3[2:1] != 2'b00;
      end
      OpSystem: begin
        if (!EN_ZICSR) begin
          illegal = 1'b1;
        end else if (f3 == 3'b000) begin
          if (data == 32'h0000_0073) dec.exc = ExcEcall;
          else if (data == 32'h0010_0073) dec.exc = ExcEbreak;
          else illegal = 1'b1;
        end else if (f3 == 3'b100) begin
          illegal = 1'b1;
        end else begin
          dec.csr_op    = f3;
          dec.imm       = {20'b0, data[31:20]};
          dec.reg_write = data[11:7] != 5'd0;
          dec.res_src   = ResMdCsr;
        end
      end
      default: illegal = 1'b1;
    endcase

    // Illegal instructions still flow so execute can trap precisely, but must not side-effect.
    if (illegal) begin
      dec.exc       = ExcIllegal;
      dec.imm       = '0;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.jump      = 1'b0;
      dec.branch    = 1'b0;
      dec.md_op     = '0;
      dec.csr_op    = '0;
    end
  end

endmodule

// File: rtl/rv_decode_pipe.sv
// Registered decode stage: one output register plus an optional skid entry for a
// registered ready towards fetch.
module rv_decode_pipe
  import rv_decode_pkg::*;
#(
  parameter bit EN_M     = 1'b0,
  parameter bit EN_ZICSR = 1'b0,
  parameter bit EN_FENCE = 1'b1,
  parameter bit SKID     = 1'b1
) (
  input logic             clk,
  input logic             rst,
  rv_decode_pipe_if.slave bus
);

  dec_bundle_t dec;
  dec_bundle_t out_q, out_d, skid_q, skid_d;
  logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic        accept, handoff;

  rv_decode_comb #(
    .EN_M    (EN_M),
    .EN_ZICSR(EN_ZICSR),
    .EN_FENCE(EN_FENCE)
  ) u_comb (
    .data (bus.data),
    .pc   (bus.pc),
    .pc_p4(bus.pc_p4),
    .dec  (dec)
  );

  if (SKID) begin : g_skid
    assign bus.ready = !skid_valid_q;
  end else begin : g_no_skid
    assign bus.ready = !out_valid_q || bus.dec_ready;
  end

  assign accept        = bus.valid && bus.ready;
  assign handoff       = out_valid_q && bus.dec_ready;
  assign bus.dec_valid = out_valid_q;
  assign bus.dec       = out_q;
  assign bus.inv_instr = out_q.exc == ExcIllegal;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (handoff || !out_valid_q) begin
      // A full skid always drains first; ready is low then, so nothing new can arrive.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && SKID) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule
